nv_op_supervisor: RTL
=====================

// Module: nv_op_supervisor
// PURPOSE
//  Issues one NV-memory operation at a time, guarded by the shared timeout timer.
//  Sits downstream of timer: drives timer.reset (tmr_clear) and consumes timer.timeout_interrupt (tmr_timeout).
//  On timeout it aborts the NV op and retries up to MAX_RETRY times, then reports OK/ERR/TIMEOUT upstream.
// PARAMETERS
//  OP_W       4  width of operation code passed through to NV interface
//  MAX_RETRY  3  retries after first attempt (total attempts = MAX_RETRY+1); >=0
//  RTRY_W     2  width of retry counter / rsp_retries; must hold MAX_RETRY
//  TOCNT_W    8  width of saturating lifetime timeout counter
// PORTS
//  clk          in   1        clock
//  reset        in   1        synchronous, active-high
//  req_valid    in   1        upstream op request
//  req_ready    out  1        supervisor can accept request
//  req_op       in   OP_W     op code, captured on req_valid&req_ready
//  nv_cmd_valid out  1        command to NV interface valid
//  nv_cmd_ready in   1        NV interface accepts command
//  nv_cmd_op    out  OP_W     captured op code (stable while nv_cmd_valid)
//  nv_done      in   1        NV op complete pulse
//  nv_err       in   1        qualifies nv_done: op failed
//  nv_abort     out  1        1-cycle pulse: abandon in-flight NV op
//  tmr_clear    out  1        to timer.reset: restart timeout window
//  tmr_timeout  in   1        from timer.timeout_interrupt (sticky until cleared)
//  rsp_valid    out  1        result valid, held until rsp_ready
//  rsp_ready    in   1        upstream accepts result
//  rsp_status   out  2        00 OK, 01 NV_ERR, 10 TIMEOUT, 11 unused
//  rsp_retries  out  RTRY_W   retries consumed by this op
//  to_count     out  TOCNT_W  lifetime timeout events, saturates at all-ones
//  busy         out  1        state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except req_ready=1; op/retry/to_count regs cleared; tmr_clear=1 during reset.
//  Registered outputs; state changes on clk edge. States: IDLE, CLEAR, ISSUE, WAIT, ABORT, RESP.
//  IDLE:  req_ready=1; on req_valid -> capture req_op, retries=0, go CLEAR. No other state accepts requests.
//  CLEAR: tmr_clear=1 for exactly 1 cycle -> ISSUE. tmr_timeout never sampled in CLEAR.
//  ISSUE: nv_cmd_valid=1, nv_cmd_op=captured op; on nv_cmd_ready -> WAIT.
//         tmr_timeout=1 while still in ISSUE -> ABORT (handshake dropped; nv_cmd_valid deasserts).
//  WAIT:  nv_done -> RESP, status = nv_err ? NV_ERR : OK.
//         tmr_timeout (no nv_done) -> ABORT. nv_done and tmr_timeout same cycle: nv_done wins.
//  ABORT: nv_abort=1 one cycle; to_count+=1 (saturating);
//         retries<MAX_RETRY -> retries+=1, go CLEAR; else RESP status=TIMEOUT.
//  RESP:  rsp_valid=1, status/retries stable; on rsp_ready -> IDLE, req_ready=1 next cycle.
//  nv_done outside WAIT ignored; nv_err ignored without nv_done.
//  Latency, no stall/retry: accept(t) -> tmr_clear(t+1) -> nv_cmd_valid(t+2); nv_done at t+k -> rsp_valid t+k+1.
//  MAX_RETRY=0: first timeout goes directly to RESP/TIMEOUT, rsp_retries=0.
//  Reset mid-op: return to IDLE next cycle, no nv_abort pulse, no rsp, to_count cleared.
// TESTING
//  1 req op=5; cmd_ready 1 cycle later; nv_done 10 cycles later, err=0 -> rsp OK, retries=0, one tmr_clear pulse.
//  2 nv_done with err=1 -> rsp NV_ERR, to_count unchanged, nv_abort never asserted.
//  3 real timer CLK_MUL=20, NV never responds, MAX_RETRY=3 -> 4 tmr_clear, 4 nv_abort, rsp TIMEOUT, retries=3, to_count=4.
//  4 timeout on 1st attempt, nv_done on 2nd -> rsp OK, retries=1, to_count=1.
//  5 nv_done and tmr_timeout same cycle in WAIT -> rsp OK, no nv_abort; rsp_ready low 5 cycles -> rsp held, req_ready=0.
//  6 reset asserted in WAIT -> next cycle IDLE, req_ready=1, busy=0; to_count forced to 255 saturates on next timeout.

Source files
------------

// File: rtl/nv_op_supervisor.sv
// nv_op_supervisor
//   Runs one NV-memory operation at a time under the shared timeout timer.
//   Each attempt restarts the timer window (tmr_clear), then issues the command
//   and waits for completion. A timeout aborts the in-flight op (nv_abort) and
//   retries up to MAX_RETRY times before reporting TIMEOUT upstream.
// Ports
//   clk, reset      clock; synchronous active-high reset
//   req_*           upstream request (valid/ready, op code)
//   nv_cmd_*        command to NV interface (valid/ready, op code)
//   nv_done/nv_err  NV completion pulse and its failure qualifier
//   nv_abort        one-cycle pulse abandoning the in-flight NV op
//   tmr_clear       drives timer.reset to restart the timeout window
//   tmr_timeout     sticky timeout from the timer
//   rsp_*           result to upstream (valid/ready, status, retries used)
//   to_count        saturating lifetime count of timeout events
//   busy            supervisor is not idle
module nv_op_supervisor #(
  parameter int OP_W      = 4,
  parameter int MAX_RETRY = 3,
  parameter int RTRY_W    = 2,
  parameter int TOCNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [OP_W-1:0]    req_op,
  output logic               nv_cmd_valid,
  input  logic               nv_cmd_ready,
  output logic [OP_W-1:0]    nv_cmd_op,
  input  logic               nv_done,
  input  logic               nv_err,
  output logic               nv_abort,
  output logic               tmr_clear,
  input  logic               tmr_timeout,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [1:0]         rsp_status,
  output logic [RTRY_W-1:0]  rsp_retries,
  output logic [TOCNT_W-1:0] to_count,
  output logic               busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_ABORT = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_NVERR = 2'b01;
  localparam logic [1:0] ST_TMO   = 2'b10;

  localparam logic [RTRY_W-1:0] MAX_RETRY_C = RTRY_W'(MAX_RETRY);

  state_t             state_q,    state_d;
  logic [OP_W-1:0]    op_q,       op_d;
  logic [RTRY_W-1:0]  retries_q,  retries_d;
  logic [1:0]         status_q,   status_d;
  logic [TOCNT_W-1:0] to_count_q, to_count_d;

  // Lifetime counter sticks at all-ones instead of wrapping.
  function automatic logic [TOCNT_W-1:0] sat_inc(input logic [TOCNT_W-1:0] v);
    return (&v) ? v : v + TOCNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      retries_q  <= '0;
      status_q   <= ST_OK;
      to_count_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      retries_q  <= retries_d;
      status_q   <= status_d;
      to_count_q <= to_count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    retries_d  = retries_q;
    status_d   = status_q;
    to_count_d = to_count_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d      = req_op;
          retries_d = '0;
          status_d  = ST_OK;
          state_d   = S_CLEAR;
        end
      end
      // The timer is being restarted here, so a stale sticky timeout is ignored.
      S_CLEAR: state_d = S_ISSUE;
      S_ISSUE: begin
        // An accepted command takes priority; a concurrent timeout is still
        // sticky and will be seen in WAIT on the next cycle.
        if (nv_cmd_ready)     state_d = S_WAIT;
        else if (tmr_timeout) state_d = S_ABORT;
      end
      S_WAIT: begin
        // Completion beats a same-cycle timeout.
        if (nv_done) begin
          status_d = nv_err ? ST_NVERR : ST_OK;
          state_d  = S_RESP;
        end else if (tmr_timeout) begin
          state_d = S_ABORT;
        end
      end
      S_ABORT: begin
        to_count_d = sat_inc(to_count_q);
        if (retries_q < MAX_RETRY_C) begin
          retries_d = retries_q + RTRY_W'(1);
          state_d   = S_CLEAR;
        end else begin
          status_d = ST_TMO;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode from registered state only; tmr_clear also follows reset so
  // the timer is held cleared while the supervisor is in reset.
  always_comb begin
    req_ready    = (state_q == S_IDLE);
    tmr_clear    = reset || (state_q == S_CLEAR);
    nv_cmd_valid = (state_q == S_ISSUE);
    nv_cmd_op    = op_q;
    nv_abort     = (state_q == S_ABORT);
    rsp_valid    = (state_q == S_RESP);
    rsp_status   = status_q;
    rsp_retries  = retries_q;
    to_count     = to_count_q;
    busy         = (state_q != S_IDLE);
  end

endmodule
